// File: rtl/filter_coef_bank_if.sv
// filter_coef_bank_if: bundles the shadow-write, commit and active-read signals of
// filter_coef_bank.
//   master : the software/sequencer side (drives strobes, addresses, write data)
//   slave  : the coefficient bank itself
// Optional macro FILTER_COEF_SHADOW_RD_EN adds rd_shadow (read the shadow bank).
interface filter_coef_bank_if #(
    parameter int unsigned COEF_W = 32,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned SEC_W  = 1
);
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [SEC_W-1:0]  wr_sec;
    logic [2:0]        wr_idx;
    logic [COEF_W-1:0] wr_data;
    logic              wr_ready;
    logic              commit_req;
    logic              sample_strobe;
    logic              commit_pending;
    logic              commit_done;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [SEC_W-1:0]  rd_sec;
    logic [2:0]        rd_idx;
    logic [COEF_W-1:0] rd_data;
    logic              rd_valid;
`ifdef FILTER_COEF_SHADOW_RD_EN
    logic              rd_shadow;
`endif

    modport master (
`ifdef FILTER_COEF_SHADOW_RD_EN
        output rd_shadow,
`endif
        output wr_en, wr_ch, wr_sec, wr_idx, wr_data,
        output commit_req, sample_strobe,
        output rd_en, rd_ch, rd_sec, rd_idx,
        input  wr_ready, commit_pending, commit_done, rd_data, rd_valid
    );

    modport slave (
`ifdef FILTER_COEF_SHADOW_RD_EN
        input  rd_shadow,
`endif
        input  wr_en, wr_ch, wr_sec, wr_idx, wr_data,
        input  commit_req, sample_strobe,
        input  rd_en, rd_ch, rd_sec, rd_idx,
        output wr_ready, commit_pending, commit_done, rd_data, rd_valid
    );
endinterface

// File: rtl/filter_coef_bank.sv
// filter_coef_bank: double-buffered biquad coefficient store (b0, b1, b2, a1, a2 per
// channel/section). Software writes the shadow bank; a commit swaps shadow and active
// on a sample boundary, then the new active bank is copied back into the new shadow
// bank (one word per cycle) so later edits start from the published set.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (both banks -> identity)
//   bus (slave) : write port + wr_ready, commit_req/sample_strobe handshake with
//                 commit_pending/commit_done, 1-cycle-latency read port
// Optional macro FILTER_COEF_SHADOW_RD_EN: bus.rd_shadow selects the shadow bank for reads.
module filter_coef_bank #(
    parameter int unsigned COEF_W = 32,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned N_SEC  = 2
) (
    input logic               clk,
    input logic               reset,
    filter_coef_bank_if.slave bus
);
    localparam int unsigned D  = N_CH * N_SEC * 5;
    localparam int unsigned AW = $clog2(D);
    localparam logic [AW-1:0]     LAST_ADDR = AW'(D - 1);
    localparam logic [COEF_W-1:0] ONE       = COEF_W'(1) << FRAC_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_COPY    = 2'd2;

    logic [COEF_W-1:0] bank [2][D];
    logic              active_sel;
    logic [1:0]        state;
    logic [AW-1:0]     copy_addr;
    logic              req_latched;   // commit_req seen during COPY
    logic              commit_done_r;
    logic [COEF_W-1:0] rd_data_r;
    logic              rd_valid_r;

    logic              wr_ready;
    logic              swap;
    logic              wr_ok;
    logic              rd_ok;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              rd_sel;

    function automatic logic addr_ok(int unsigned ch, int unsigned sec, int unsigned idx);
        return (ch < N_CH) && (sec < N_SEC) && (idx < 5);
    endfunction

    function automatic logic [AW-1:0] flat_addr(int unsigned ch, int unsigned sec,
                                                int unsigned idx);
        int unsigned a;
        a = (ch * N_SEC + sec) * 5 + idx;
        return a[AW-1:0];
    endfunction

    always_comb begin
        wr_ready = !reset && (state != ST_COPY);
        swap     = ((state == ST_IDLE) && bus.commit_req && bus.sample_strobe) ||
                   ((state == ST_PENDING) && bus.sample_strobe);
        wr_ok    = bus.wr_en && wr_ready &&
                   addr_ok(32'(bus.wr_ch), 32'(bus.wr_sec), 32'(bus.wr_idx));
        rd_ok    = addr_ok(32'(bus.rd_ch), 32'(bus.rd_sec), 32'(bus.rd_idx));
        wr_addr  = flat_addr(32'(bus.wr_ch), 32'(bus.wr_sec), 32'(bus.wr_idx));
        rd_addr  = flat_addr(32'(bus.rd_ch), 32'(bus.rd_sec), 32'(bus.rd_idx));
`ifdef FILTER_COEF_SHADOW_RD_EN
        rd_sel   = active_sel ^ bus.rd_shadow;
`else
        rd_sel   = active_sel;
`endif
    end

    // Control, handshake outputs and read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            active_sel    <= 1'b0;
            copy_addr     <= '0;
            req_latched   <= 1'b0;
            commit_done_r <= 1'b0;
            rd_data_r     <= '0;
            rd_valid_r    <= 1'b0;
        end else begin
            commit_done_r <= swap;
            rd_valid_r    <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_r <= rd_ok ? bank[rd_sel][rd_addr] : '0;
            end
            case (state)
                ST_IDLE, ST_PENDING: begin
                    if (swap) begin
                        active_sel  <= ~active_sel;
                        state       <= ST_COPY;
                        copy_addr   <= '0;
                        req_latched <= 1'b0;
                    end else if ((state == ST_IDLE) && bus.commit_req) begin
                        state <= ST_PENDING;
                    end
                end
                ST_COPY: begin
                    // sample_strobe is deliberately ignored here.
                    if (bus.commit_req) req_latched <= 1'b1;
                    copy_addr <= copy_addr + 1'b1;
                    if (copy_addr == LAST_ADDR) begin
                        state       <= (req_latched || bus.commit_req) ? ST_PENDING : ST_IDLE;
                        req_latched <= 1'b0;
                        copy_addr   <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage. Copy and software writes never overlap: wr_ready is low during COPY.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(D); i++) begin
                    bank[b][i] <= (i % 5 == 0) ? ONE : '0;
                end
            end
        end else if (state == ST_COPY) begin
            bank[~active_sel][copy_addr] <= bank[active_sel][copy_addr];
        end else if (wr_ok) begin
            bank[~active_sel][wr_addr] <= bus.wr_data;
        end
    end

    assign bus.wr_ready       = wr_ready;
    assign bus.commit_pending = (state == ST_PENDING) || ((state == ST_COPY) && req_latched);
    assign bus.commit_done    = commit_done_r;
    assign bus.rd_data        = rd_data_r;
    assign bus.rd_valid       = rd_valid_r;
endmodule

// File: tb/tb_filter_coef_bank.sv
// Directed bench for filter_coef_bank (N_CH=4, N_SEC=2, D=40).
module tb_filter_coef_bank;
    localparam int unsigned COEF_W = 32;
    localparam int unsigned FRAC_W = 16;
    localparam int unsigned N_CH   = 4;
    localparam int unsigned N_SEC  = 2;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned SEC_W  = 1;
    localparam int          D      = 40;
    localparam logic [31:0] ONE    = 32'h0001_0000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    filter_coef_bank_if #(.COEF_W(COEF_W), .CH_W(CH_W), .SEC_W(SEC_W)) bus ();

    filter_coef_bank #(
        .COEF_W(COEF_W),
        .FRAC_W(FRAC_W),
        .N_CH  (N_CH),
        .N_SEC (N_SEC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_sec = '0; bus.wr_idx = '0; bus.wr_data = '0;
        bus.commit_req = 1'b0; bus.sample_strobe = 1'b0;
        bus.rd_en = 1'b0; bus.rd_ch = '0; bus.rd_sec = '0; bus.rd_idx = '0;
`ifdef FILTER_COEF_SHADOW_RD_EN
        bus.rd_shadow = 1'b0;
`endif
    endtask

    task automatic write_coef(input int ch, input int sec, input int idx, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_ch = ch[1:0]; bus.wr_sec = sec[0:0]; bus.wr_idx = idx[2:0];
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic check_read(input string tag, input int ch, input int sec, input int idx,
                              input logic shadow, input logic [31:0] exp);
        bus.rd_en = 1'b1; bus.rd_ch = ch[1:0]; bus.rd_sec = sec[0:0]; bus.rd_idx = idx[2:0];
`ifdef FILTER_COEF_SHADOW_RD_EN
        bus.rd_shadow = shadow;
`else
        if (shadow) $display("note: shadow read requested without shadow port");
`endif
        step();
        bus.rd_en = 1'b0;
`ifdef FILTER_COEF_SHADOW_RD_EN
        bus.rd_shadow = 1'b0;
`endif
        check({tag, "_data"}, bus.rd_data, exp);
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    endtask

    // Same-cycle commit_req + sample_strobe from IDLE; returns at t+1.
    task automatic commit_now();
        bus.commit_req = 1'b1; bus.sample_strobe = 1'b1;
        step();
        bus.commit_req = 1'b0; bus.sample_strobe = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (!bus.wr_ready && guard < 200) begin
            step();
            guard++;
        end
        check({tag, "_ready_timeout"}, 32'(bus.wr_ready), 32'd1);
    endtask

    initial begin
        int  lows;
        int  guard;
        int  k;
        logic seen;

        clear_inputs();
        reset = 1'b1;
        repeat (3) step();

        // Reset state.
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_commit_done", 32'(bus.commit_done), 32'd0);
        check("rst_commit_pending", 32'(bus.commit_pending), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Identity defaults everywhere; idx 5..7 read as 0 but valid.
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < 8; i++)
                    check_read($sformatf("ident_c%0d_s%0d_i%0d", c, s, i), c, s, i, 1'b0,
                               (i == 0) ? ONE : 32'd0);

        // rd_en low: valid drops, data holds.
        check_read("hold_pre", 0, 0, 0, 1'b0, ONE);
        step();
        check("hold_valid", 32'(bus.rd_valid), 32'd0);
        check("hold_data", bus.rd_data, ONE);

        // Shadow write not visible until commit; invalid idx dropped.
        write_coef(1, 0, 3, 32'h0001_E339);
        write_coef(1, 0, 5, 32'hFFFF_FFFF);
        check_read("precommit_active", 1, 0, 3, 1'b0, 32'd0);

        // commit_req, strobe 3 cycles later; D-cycle wr_ready gap with a dropped write.
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        check("pending_after_req", 32'(bus.commit_pending), 32'd1);
        step();
        step();
        bus.sample_strobe = 1'b1;
        bus.rd_en = 1'b1; bus.rd_ch = 2'd1; bus.rd_sec = 1'b0; bus.rd_idx = 3'd3;
        step();
        bus.sample_strobe = 1'b0;
        check("swap_commit_done", 32'(bus.commit_done), 32'd1);
        check("swap_pending_clr", 32'(bus.commit_pending), 32'd0);
        check("strobe_cycle_read_old", bus.rd_data, 32'd0);
        lows = bus.wr_ready ? 0 : 1;
        step();
        bus.rd_en = 1'b0;
        check("read_after_swap_new", bus.rd_data, 32'h0001_E339);
        check("commit_done_one_cycle", 32'(bus.commit_done), 32'd0);
        if (!bus.wr_ready) lows++;
        guard = 0;
        while (!bus.wr_ready && guard < 200) begin
            bus.wr_en = (lows == 5); bus.wr_ch = 2'd0; bus.wr_sec = 1'b0; bus.wr_idx = 3'd1;
            bus.wr_data = 32'hDEAD_BEEF;
            step();
            bus.wr_en = 1'b0;
            guard++;
            if (!bus.wr_ready) lows++;
        end
        check("copy_ready_low_cycles", lows, D);

        // Immediate swap: commit_pending never rises; copied shadow republished.
        commit_now();
        check("imm_commit_done", 32'(bus.commit_done), 32'd1);
        seen = bus.commit_pending;
        guard = 0;
        while (!bus.wr_ready && guard < 200) begin
            step();
            guard++;
            if (bus.commit_pending) seen = 1'b1;
        end
        check("imm_pending_never", 32'(seen), 32'd0);
        check_read("imm_copied_val", 1, 0, 3, 1'b0, 32'h0001_E339);
        check_read("dropped_write_absent", 0, 0, 1, 1'b0, 32'd0);
        check_read("imm_b0_default", 0, 0, 0, 1'b0, ONE);
        check_read("invalid_idx_zero", 1, 0, 5, 1'b0, 32'd0);
`ifdef FILTER_COEF_SHADOW_RD_EN
        check_read("shadow_dropped_absent", 0, 0, 1, 1'b1, 32'd0);
        write_coef(0, 1, 2, 32'h0000_1234);
        check_read("shadow_sees_write", 0, 1, 2, 1'b1, 32'h0000_1234);
        check_read("active_not_yet", 0, 1, 2, 1'b0, 32'd0);
`endif

        // commit_req during COPY latches; strobes during COPY are ignored.
        write_coef(2, 1, 4, 32'hFFFF_8000);
        commit_now();
        seen = 1'b0;
        k = 0;
        while (!bus.wr_ready && k < 200) begin
            bus.commit_req = (k == 3);
            bus.sample_strobe = (k == 6) || (k == 20);
            step();
            bus.commit_req = 1'b0; bus.sample_strobe = 1'b0;
            k++;
            if (bus.commit_done) seen = 1'b1;
            if (k == 10) check("pending_in_copy", 32'(bus.commit_pending), 32'd1);
        end
        check("no_swap_in_copy", 32'(seen), 32'd0);
        check("pending_after_copy", 32'(bus.commit_pending), 32'd1);
        check_read("copy_commit_active", 2, 1, 4, 1'b0, 32'hFFFF_8000);
        write_coef(2, 1, 4, 32'h1234_5678);
        check("still_pending", 32'(bus.commit_pending), 32'd1);
        bus.sample_strobe = 1'b1;
        step();
        bus.sample_strobe = 1'b0;
        check("late_swap_done", 32'(bus.commit_done), 32'd1);
        wait_ready("late_swap");
        check_read("pending_write_included", 2, 1, 4, 1'b0, 32'h1234_5678);
        check_read("older_val_kept", 1, 0, 3, 1'b0, 32'h0001_E339);

        // Reset 10 cycles into COPY.
        write_coef(3, 1, 2, 32'hA5A5_A5A5);
        commit_now();
        repeat (8) step();
        check_read("mid_copy_read", 0, 0, 0, 1'b0, ONE);
        reset = 1'b1;
        step();
        check("rst_copy_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_copy_done", 32'(bus.commit_done), 32'd0);
        check("rst_copy_pending", 32'(bus.commit_pending), 32'd0);
        check("rst_copy_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_copy_rd_data", bus.rd_data, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_copy_ready_after", 32'(bus.wr_ready), 32'd1);
        check_read("rst_active_a", 3, 1, 2, 1'b0, 32'd0);
        check_read("rst_active_b", 2, 1, 4, 1'b0, 32'd0);
        check_read("rst_active_b0", 3, 1, 0, 1'b0, ONE);
        commit_now();
        wait_ready("rst_shadow");
        check_read("rst_shadow_a", 3, 1, 2, 1'b0, 32'd0);
        check_read("rst_shadow_b", 1, 0, 3, 1'b0, 32'd0);
        check_read("rst_shadow_b0", 1, 0, 0, 1'b0, ONE);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/filter_coef_bank.md
# filter_coef_bank

Multi-channel, multi-section coefficient store for the IIR biquad datapath. It replaces the fixed five-word reset-loaded coefficient ROM. Each (channel, section) holds five signed fixed-point coefficients b0, b1, b2, a1, a2, stored in a double-buffered bank. Software writes a shadow bank at any time, and a commit swaps shadow and active only on a sample boundary, so a running filter never sees a half-updated coefficient set.

## Interface
- COEF_W, 32, coefficient width (signed, Q(COEF_W-FRAC_W).FRAC_W)
- FRAC_W, 16, fractional bits; 1.0 = 2^FRAC_W
- N_CH, 4, channels (>=1)
- N_SEC, 2, biquad sections per channel (>=1)
- CH_W / SEC_W, derived: max(1, clog2(N_CH)) / max(1, clog2(N_SEC))

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  shadow write strobe
- wr_ch / wr_sec / wr_idx  in  CH_W / SEC_W / 3  write address
- wr_data  in  COEF_W  write data
- wr_ready  out  1  high when writes are accepted
- commit_req  in  1  one-cycle request to publish the shadow bank
- sample_strobe  in  1  sample boundary from the filter sequencer
- commit_pending  out  1  commit requested, not yet applied
- commit_done  out  1  one-cycle pulse when the swap is applied
- rd_en  in  1  active read strobe
- rd_ch / rd_sec / rd_idx  in  CH_W / SEC_W / 3  read address
- rd_data  out  COEF_W  active coefficient
- rd_valid  out  1  rd_data valid

## Operation
- Index map:
  - idx 0=b0 (n1), 1=b1 (n2), 2=b2 (n3), 3=a1 (d1), 4=a2 (d2).
  - idx 5..7 are invalid. Writes to them are dropped. Reads of them return 0, with rd_valid still asserted.
  - Out-of-range ch or sec behaves the same way.
- Storage: two banks of D = N_CH*N_SEC*5 words each. The active_sel register selects the active bank.
- Reset:
  - Both banks load the identity default in every (ch, sec): b0 = 1<<FRAC_W, all others 0.
  - active_sel=0, state=IDLE, all outputs 0, wr_ready=0 during reset, then 1.
- FSM:
  - IDLE:
    - commit_req with no sample_strobe -> PENDING.
    - sample_strobe && commit_req in the same cycle -> swap immediately.
  - PENDING: sample_strobe -> swap.
  - Swap:
    - active_sel toggles and commit_done pulses.
    - The FSM enters COPY at address 0.
  - COPY:
    - Copies new-active into new-shadow, one word per cycle, D cycles.
    - After the last word -> IDLE, or -> PENDING if a commit_req arrived during COPY.
- wr_ready is low throughout COPY. A wr_en with wr_ready=0 is dropped; there is no error flag.
- Writes in IDLE and PENDING go to the shadow bank. A write in PENDING is included in the pending commit.
- commit_req in PENDING is ignored, since the request is already pending. commit_pending=1 in PENDING, and in COPY when a request is latched.
- sample_strobe in COPY has no effect on the swap.
- Arithmetic: none. Data is stored bit-exact, with no saturation or sign handling.

## Timing
- Read latency is 1 cycle. rd_en at cycle t gives rd_data/rd_valid at t+1.
- Reads use active_sel as registered at cycle t.
- When rd_en=0, rd_valid=0 and rd_data holds its last value.
- Swap: qualifying sample_strobe at t gives:
  - active_sel new at t+1;
  - commit_done=1 at t+1 only;
  - wr_ready=0 over t+1..t+D;
  - wr_ready=1 at t+D+1.
- A read at cycle t (the strobe cycle) returns the old bank. A read at t+1 returns the new bank.
- Write: wr_en at t is visible in the shadow bank at t+1. It becomes active only after a swap.
- Reset mid-COPY or mid-PENDING aborts the operation. The pending request is lost and the defaults are restored on the next cycle.

## Configuration
- FILTER_COEF_SHADOW_RD_EN:
  - Defined: adds input rd_shadow (1 bit). When rd_shadow=1, reads return the shadow bank with the same 1-cycle latency. During COPY, shadow reads return the partially copied contents.
  - Undefined: no port, and reads always use the active bank.

## Test plan
- Reset, then read every (ch, sec, idx) -> b0=0x00010000, others 0, rd_valid at t+1. idx 5..7 -> 0.
- Write ch1/sec0/idx3 = 0x0001E339, then read without committing -> active value still 0. Then commit_req, then sample_strobe 3 cycles later -> commit_done 1 cycle after the strobe, and the read returns 0x0001E339.
- Commit with N_CH=4, N_SEC=2 (D=40) -> wr_ready low for exactly 40 cycles. A wr_en during that window is dropped, and a later shadow read (macro on) shows the dropped write absent.
- commit_req and sample_strobe in the same cycle from IDLE -> immediate swap, commit_pending never asserts.
- commit_req during COPY -> commit_pending=1 after COPY ends. The swap occurs on the first strobe after that, not on any strobe during COPY.
- Reset asserted 10 cycles into COPY -> next cycle all outputs 0, both banks at identity, wr_ready=1 after reset deasserts.
